// File: rtl/tick_gen.sv
// Programmable enable-pulse generator: divides clk_i by a runtime divisor and emits
// one-cycle ticks, either as a fixed-length burst or continuously. Optional feature: TICK_GEN_RELOAD_EN.
module tick_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   a_rst_i,
    input  logic                   start_i,
    input  logic                   stop_i,
`ifdef TICK_GEN_RELOAD_EN
    input  logic                   div_load_i,
`endif
    input  logic [DIV_WIDTH-1:0]   div_i,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic                   tick_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [BURST_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state_q;
    state_t                 state_d;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   presc_q;
    logic [BURST_WIDTH-1:0] burst_q;
    logic [BURST_WIDTH-1:0] cnt_q;

    logic                   start_ok;
    logic                   wrap;
    logic                   last_tick;
    logic                   tick_d;
    logic                   done_d;

    // A divisor of zero behaves like one so the prescaler compare never underflows.
    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? DIV_WIDTH'(1) : d;
    endfunction

    assign start_ok  = (state_q == IDLE) && start_i && !stop_i;
    assign wrap      = (state_q == RUN) && (presc_q == div_q - DIV_WIDTH'(1));
    assign last_tick = (burst_q != '0) && (cnt_q == burst_q - BURST_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = RUN;
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    tick_d = 1'b1;
                    if (last_tick) state_d = DONE;
                end
            end
            DONE: begin
                done_d  = !stop_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            state_q <= IDLE;
            tick_o  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_o  <= tick_d;
            busy_o  <= (state_q == RUN);
            done_o  <= done_d;
        end
    end

`ifdef TICK_GEN_RELOAD_EN
    logic [DIV_WIDTH-1:0] shadow_q;
    logic                 pend_q;
`endif

    always_ff @(posedge clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            div_q    <= '0;
            burst_q  <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
`ifdef TICK_GEN_RELOAD_EN
            shadow_q <= '0;
            pend_q   <= 1'b0;
`endif
        end else if (start_ok) begin
            div_q    <= clamp_div(div_i);
            burst_q  <= burst_i;
            presc_q  <= '0;
            cnt_q    <= '0;
`ifdef TICK_GEN_RELOAD_EN
            pend_q   <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            if (wrap) begin
                presc_q <= '0;
                // Continuous runs keep ticking forever, so the count saturates.
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + BURST_WIDTH'(1);
            end else begin
                presc_q <= presc_q + DIV_WIDTH'(1);
            end
`ifdef TICK_GEN_RELOAD_EN
            // A new divisor only takes effect at a period boundary; a load on that same edge wins.
            if (wrap) begin
                if (div_load_i || pend_q)
                    div_q <= clamp_div(div_load_i ? div_i : shadow_q);
                pend_q <= 1'b0;
            end else if (div_load_i) begin
                shadow_q <= div_i;
                pend_q   <= 1'b1;
            end
`endif
        end
    end

endmodule
